param_alu: RTL
==============

PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL have parameter: W, 16, operand width (W >= 4, even).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request strobe; accepted only when busy=0.
REQ-005 SHALL have port: dtype  input  4  4'h1 signed, 4'h2 unsigned; other values are invalid.
REQ-006 SHALL have port: operator  input  5  5'h01 add, 5'h02 sub, 5'h03 mul, 5'h04 div; other values are invalid.
REQ-007 SHALL have ports: src1 and src2, input, W each; operands, with src1 as dividend.
REQ-008 SHALL have port: busy  output  1  operation in progress.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  error flag, valid while done=1.
REQ-011 SHALL have port: calc_res  output  2W  registered result.

Function
REQ-012 SHALL accept a request on any rising edge with start=1 and busy=0, capturing dtype, operator, src1 and src2; acceptance cycle is cycle 0.
REQ-013 SHALL ignore start while busy=1; captured operands SHALL stay unchanged.
REQ-014 SHALL use a state machine with states IDLE, ITER, DONE; IDLE->DONE for add/sub/invalid/div-by-zero; IDLE->ITER for mul/div; ITER->DONE after exactly W iterations; DONE->IDLE after one cycle.
REQ-015 SHALL assert done only in DONE, for exactly one cycle; add/sub/error at cycle 1, mul/div at cycle W+1.
REQ-016 SHALL assert busy in ITER only; busy SHALL be 0 in DONE, and a start in the DONE cycle SHALL be accepted.
REQ-017 SHALL compute add/sub at 2W width, sign-extending operands when signed and zero-extending when unsigned; unsigned negative differences wrap modulo 2^(2W).
REQ-018 SHALL compute mul as shift-add, one partial product per cycle, with a full 2W product; signed mul operates on magnitudes and negates when operand signs differ.
REQ-019 SHALL compute div as restoring division, one quotient bit per cycle; calc_res = {quotient[W-1:0], remainder[W-1:0]}.
REQ-020 SHALL truncate signed quotients toward zero; the remainder takes the dividend's sign.
REQ-021 SHALL handle signed most-negative / -1 by returning quotient 0x8..0 (wrapped) and remainder 0, with err=0.
REQ-022 SHALL, on divide by zero, skip ITER and return quotient all-ones and remainder = src1, with err=1.
REQ-023 SHALL, on invalid dtype or operator, set calc_res=0 and err=1, with done at cycle 1.
REQ-024 SHALL update calc_res only in the DONE cycle and hold it until the next DONE.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, clear state to IDLE, busy=0, done=0, err=0 and calc_res=0.
REQ-026 SHALL let reset abort ITER mid-operation with no done pulse; the first start after rst deasserts SHALL be accepted.
REQ-027 SHALL give rst priority over a coincident start.

Configuration
REQ-028 SHALL, with macro PARAM_ALU_DIV_EN defined, implement divide per REQ-019 to REQ-022.
REQ-029 SHALL, without PARAM_ALU_DIV_EN, remove divider hardware and treat operator 5'h04 as invalid per REQ-023.

Verification (W=16)
REQ-030 SHALL cover: unsigned add 0xFFFF+0x0001 -> done at cycle 1, calc_res 0x00010000, err 0.
REQ-031 SHALL cover: signed sub 0x8000-0x0001 -> calc_res 0xFFFF7FFF at cycle 1; unsigned sub 0x0001-0x0002 -> calc_res 0xFFFFFFFF.
REQ-032 SHALL cover: signed mul 0xFFFD*0x0005 -> done at cycle 17, calc_res 0xFFFFFFF1; a start pulsed at cycle 5 is ignored.
REQ-033 SHALL cover: unsigned div 100/7 -> calc_res 0x000E0002 at cycle 17; signed div 0xFFF9/0x0002 -> calc_res 0xFFFDFFFF.
REQ-034 SHALL cover: div 0x1234/0 -> done at cycle 1, err 1, calc_res 0xFFFF1234; operator 5'h05 -> err 1, calc_res 0.
REQ-035 SHALL cover: rst at cycle 8 of a mul -> no done pulse, all outputs 0, and the next add completes normally.

Source files
------------

// File: rtl/param_alu_if.sv
// Request/response bundle for param_alu: request strobe, operand fields,
// and the busy/done/err/calc_res completion signals.
interface param_alu_if #(
  parameter int W = 16
) ();
  logic           start;
  logic [3:0]     dtype;
  logic [4:0]     operator;
  logic [W-1:0]   src1;
  logic [W-1:0]   src2;
  logic           busy;
  logic           done;
  logic           err;
  logic [2*W-1:0] calc_res;

  modport master (
    output start, dtype, operator, src1, src2,
    input  busy, done, err, calc_res
  );

  modport slave (
    input  start, dtype, operator, src1, src2,
    output busy, done, err, calc_res
  );
endinterface

// File: rtl/param_alu.sv
// Multi-cycle ALU: add/sub in one step, shift-add mul and restoring div over W steps.
// Divider present only when PARAM_ALU_DIV_EN is defined; otherwise operator 5'h04 is invalid.
//
// state | meaning
// IDLE  | waiting for start
// ITER  | one mul partial product / div quotient bit per cycle
// DONE  | result and err valid, done pulsed
module param_alu #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      rst,
  param_alu_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state;

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic           neg_q;

  logic           is_signed, ty_ok, op_ok, is_add, is_sub, is_mul, neg;
  logic [2*W-1:0] ext1, ext2, addsub;
  logic [W-1:0]   mag1, mag2;
  logic [2*W-1:0] mul_acc_n, mul_res;

  assign is_signed = (bus.dtype == 4'h1);
  assign ty_ok     = (bus.dtype == 4'h1) || (bus.dtype == 4'h2);
  assign is_add    = (bus.operator == 5'h01);
  assign is_sub    = (bus.operator == 5'h02);
  assign is_mul    = (bus.operator == 5'h03);

  assign ext1   = is_signed ? {{W{bus.src1[W-1]}}, bus.src1} : {{W{1'b0}}, bus.src1};
  assign ext2   = is_signed ? {{W{bus.src2[W-1]}}, bus.src2} : {{W{1'b0}}, bus.src2};
  assign addsub = is_sub ? ext1 - ext2 : ext1 + ext2;

  // Mul/div run on magnitudes; the sign is restored when the result is stored.
  assign mag1 = (is_signed && bus.src1[W-1]) ? -bus.src1 : bus.src1;
  assign mag2 = (is_signed && bus.src2[W-1]) ? -bus.src2 : bus.src2;
  assign neg  = is_signed && (bus.src1[W-1] ^ bus.src2[W-1]);

  assign mul_acc_n = mplier[0] ? acc + mcand : acc;
  assign mul_res   = neg_q ? -mul_acc_n : mul_acc_n;

`ifdef PARAM_ALU_DIV_EN
  logic           is_div, div_q, neg_r, q_bit;
  logic [W:0]     r_sh, diff;
  logic [W-1:0]   rem_n, quo_n, rem_f, quo_f;

  assign is_div = (bus.operator == 5'h04);
  assign op_ok  = is_add || is_sub || is_mul || is_div;

  // Remainder lives in acc[W-1:0], divisor in mcand[W-1:0], dividend/quotient in mplier.
  assign r_sh  = {acc[W-1:0], mplier[W-1]};
  assign diff  = r_sh - {1'b0, mcand[W-1:0]};
  assign q_bit = ~diff[W];
  assign rem_n = q_bit ? diff[W-1:0] : r_sh[W-1:0];
  assign quo_n = {mplier[W-2:0], q_bit};
  assign quo_f = neg_q ? -quo_n : quo_n;
  assign rem_f = neg_r ? -rem_n : rem_n;
`else
  assign op_ok  = is_add || is_sub || is_mul;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.calc_res <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg_q    <= 1'b0;
`ifdef PARAM_ALU_DIV_EN
      div_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else if (state != ITER && bus.start) begin
      state    <= DONE;
      bus.busy <= 1'b0;
      bus.done <= 1'b1;
      bus.err  <= 1'b0;
      if (!ty_ok || !op_ok) begin
        bus.err      <= 1'b1;
        bus.calc_res <= '0;
      end else if (is_add || is_sub) begin
        bus.calc_res <= addsub;
`ifdef PARAM_ALU_DIV_EN
      end else if (is_div && bus.src2 == '0) begin
        bus.err      <= 1'b1;
        bus.calc_res <= {{W{1'b1}}, bus.src1};
`endif
      end else begin
        state    <= ITER;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
        cnt      <= CW'(W - 1);
        acc      <= '0;
        neg_q    <= neg;
`ifdef PARAM_ALU_DIV_EN
        div_q    <= is_div;
        neg_r    <= is_signed && bus.src1[W-1];
        mplier   <= is_div ? mag1 : mag2;
        mcand    <= {{W{1'b0}}, (is_div ? mag2 : mag1)};
`else
        mplier   <= mag2;
        mcand    <= {{W{1'b0}}, mag1};
`endif
      end
    end else begin
      case (state)
        ITER: begin
`ifdef PARAM_ALU_DIV_EN
          if (div_q) begin
            acc    <= {{W{1'b0}}, rem_n};
            mplier <= quo_n;
          end else begin
            acc    <= mul_acc_n;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
          end
`else
          acc    <= mul_acc_n;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
`endif
          if (cnt == '0) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.err  <= 1'b0;
`ifdef PARAM_ALU_DIV_EN
            bus.calc_res <= div_q ? {quo_f, rem_f} : mul_res;
`else
            bus.calc_res <= mul_res;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
